i2c_slave_ctrl: RTL and testbench
=================================

Name: i2c_slave_ctrl

Overview:
- I2C target (slave) controller; it is the responder for the team's I2C master controller on the same two-wire bus.
- Oversamples SCL/SDA on the system clock, detects START/STOP, matches a 7-bit address and ACKs it.
- Delivers written bytes to user logic; fetches read bytes from user logic on request.
- Drives SDA open-drain only: the block can pull SDA low or release it. SCL is input only; clock stretching is not supported.

Parameters:
- SLAVE_ADDR, 7'h50, 7-bit bus address this target responds to.
- SYNC_STAGES, 2, synchronizer flops on scl_in/sda_in (minimum 2).

Ports:
- clk  input  1  system clock, at least 8x the SCL frequency.
- rst_n  input  1  synchronous active-low reset.
- scl_in  input  1  raw bus SCL level.
- sda_in  input  1  raw bus SDA level.
- sda_oe  output  1  1 = pull SDA low; 0 = release.
- wr_data  output  8  byte received from the master.
- wr_valid  output  1  1-cycle pulse; wr_data is valid in that cycle.
- rd_req  output  1  1-cycle pulse requesting the next read byte.
- rd_data  input  8  read byte; must be stable on the cycle after rd_req.
- start_det  output  1  1-cycle pulse on START or repeated START.
- stop_det  output  1  1-cycle pulse on STOP.
- busy  output  1  1 from an address match until STOP/IDLE.
- state  output  4  current FSM state, for debug.

Behaviour:
- Reset (synchronous, rst_n=0 at posedge clk):
  - FSM goes to IDLE.
  - sda_oe, wr_valid, rd_req, start_det, stop_det, busy = 0; wr_data = 0.
  - Synchronizer and previous-level flops load 1 (bus-idle level).
  - Reset mid-transfer releases SDA within 1 cycle.
- Input conditioning:
  - scl_s/sda_s = SYNC_STAGES-flop synchronized inputs; scl_d/sda_d = those values delayed 1 cycle.
  - scl_rise = scl_s & ~scl_d; scl_fall = ~scl_s & scl_d.
  - START = sda_fall while scl_s=1; STOP = sda_rise while scl_s=1.
  - SDA edges while SCL is high take priority over the data path in the same cycle.
- FSM states:
  - IDLE = 0. Wait for START.
  - ADDR = 1. Sample 8 bits (addr[6:0], rw) MSB first on scl_rise, using a 3-bit counter.
  - ADDR_ACK = 2. Drive ACK on match; else go to IDLE with no ACK.
  - WR_BYTE = 3. Sample 8 bits on scl_rise.
  - WR_ACK = 4. Drive ACK; wr_valid pulses on the scl_rise of the ACK bit.
  - RD_BYTE = 5. Shift out 8 bits MSB first.
  - RD_ACK = 6. SDA released; sample the master's ACK/NACK on scl_rise.
  - WAIT_STOP = 7. SDA released; wait for START or STOP.
- Transitions:
  - START from any state: go to ADDR, clear bit counter, sda_oe=0, start_det pulse. This covers repeated START.
  - STOP from any state: go to IDLE, sda_oe=0, busy=0, stop_det pulse.
- Address phase:
  - After the 8th scl_rise in ADDR: if addr matches, busy=1 and go to ADDR_ACK. Otherwise go to IDLE, ignoring the bus until the next START.
  - ADDR_ACK: sda_oe=1 on the next scl_fall; released on the following scl_fall.
  - Same cycle as the release: if rw=0, go to WR_BYTE.
  - If rw=1: pulse rd_req 1 cycle earlier, on the ACK bit's scl_rise. Load the shift register from rd_data the next cycle. Drive bit 7 (sda_oe = ~bit) at the release edge; go to RD_BYTE.
- Write path:
  - WR_BYTE: after the 8th scl_rise, go to WR_ACK.
  - WR_ACK: sda_oe=1 from the next scl_fall to the following scl_fall, then back to WR_BYTE.
  - There is no byte limit; every byte is ACKed.
- Read path:
  - RD_BYTE: update sda_oe on each scl_fall.
  - After the 8th bit's scl_fall, release SDA and go to RD_ACK.
  - RD_ACK on scl_rise:
    - SDA low (ACK): pulse rd_req; load the next byte 1 cycle later; drive bit 7 on the next scl_fall; go to RD_BYTE.
    - SDA high (NACK): go to WAIT_STOP.
- Widths: bit counter is 3 bits and wraps 7 to 0 at byte end. Shift registers are 8 bits.
- Latency: wr_data/wr_valid are 0 SCL edges after the ACK scl_rise, i.e. SYNC_STAGES+1 clk after the raw SCL rise.

Test Plan:
- Write: START, 0xA0 (0x50,W), 0x12, 0x34, STOP -> ACK on all three bytes; wr_valid twice with 0x12 then 0x34; stop_det 1 pulse; busy=0 after.
- Mismatch: START, 0xA2, 0x55, STOP -> sda_oe never 1; no wr_valid; busy stays 0; start_det and stop_det each pulse once.
- Read: START, 0xA1; rd_data=0xC3 then 0x5A; master ACKs the first byte and NACKs the second -> bus carries 0xC3, 0x5A; rd_req exactly 2 pulses; FSM in WAIT_STOP, then IDLE after STOP.
- Repeated START: write 0xA0, 0x07, then Sr, 0xA1, read 1 byte with NACK, then STOP -> wr_data=0x07; start_det 2 pulses; read byte matches rd_data.
- STOP inserted after bit 4 of a write byte -> FSM goes to IDLE; no wr_valid; sda_oe=0.
- rst_n=0 for 1 cycle while driving the ACK (sda_oe=1) -> sda_oe=0 next cycle; state=IDLE; a subsequent valid transfer succeeds.

Source files
------------

// File: rtl/i2c_slave_ctrl.sv
// I2C target controller: oversampled SCL/SDA, START/STOP detection, 7-bit
// address match with ACK, byte delivery to user logic on writes and byte
// fetch from user logic on reads. SDA is driven open-drain through sda_oe.
module i2c_slave_ctrl #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] wr_data,
  output logic       wr_valid,
  output logic       rd_req,
  input  logic [7:0] rd_data,
  output logic       start_det,
  output logic       stop_det,
  output logic       busy,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    ADDR      = 4'd1,
    ADDR_ACK  = 4'd2,
    WR_BYTE   = 4'd3,
    WR_ACK    = 4'd4,
    RD_BYTE   = 4'd5,
    RD_ACK    = 4'd6,
    WAIT_STOP = 4'd7
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic scl_s, sda_s, scl_d, sda_d;
  logic scl_rise, scl_fall, start_cond, stop_cond;

  state_t     state_q, state_n;
  logic [2:0] bit_cnt_q, bit_cnt_n;
  logic [7:0] shift_in_q, shift_in_n;
  logic [7:0] shift_out_q, shift_out_n;
  logic       rw_q, rw_n;
  logic       ack_on_q, ack_on_n;
  logic       prime_q, prime_n;
  logic       load_q, load_n;
  logic       sda_oe_q, sda_oe_n;
  logic [7:0] wr_data_q, wr_data_n;
  logic       wr_valid_q, wr_valid_n;
  logic       rd_req_q, rd_req_n;
  logic       start_det_q, start_det_n;
  logic       stop_det_q, stop_det_n;
  logic       busy_q, busy_n;

  // Synchronize the raw bus lines and keep a one-cycle-old copy; idle bus level is 1
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
      scl_d    <= scl_s;
      sda_d    <= sda_s;
    end
  end

  assign scl_s      = scl_sync[SYNC_STAGES-1];
  assign sda_s      = sda_sync[SYNC_STAGES-1];
  assign scl_rise   = scl_s & ~scl_d;
  assign scl_fall   = ~scl_s & scl_d;
  assign start_cond = scl_s & sda_d & ~sda_s;
  assign stop_cond  = scl_s & ~sda_d & sda_s;

  // State and datapath registers; the rd_data capture happens the cycle after rd_req
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= 3'd0;
      shift_in_q  <= 8'd0;
      shift_out_q <= 8'd0;
      rw_q        <= 1'b0;
      ack_on_q    <= 1'b0;
      prime_q     <= 1'b0;
      load_q      <= 1'b0;
      sda_oe_q    <= 1'b0;
      wr_data_q   <= 8'd0;
      wr_valid_q  <= 1'b0;
      rd_req_q    <= 1'b0;
      start_det_q <= 1'b0;
      stop_det_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_n;
      bit_cnt_q   <= bit_cnt_n;
      shift_in_q  <= shift_in_n;
      shift_out_q <= shift_out_n;
      rw_q        <= rw_n;
      ack_on_q    <= ack_on_n;
      prime_q     <= prime_n;
      load_q      <= load_n;
      sda_oe_q    <= sda_oe_n;
      wr_data_q   <= wr_data_n;
      wr_valid_q  <= wr_valid_n;
      rd_req_q    <= rd_req_n;
      start_det_q <= start_det_n;
      stop_det_q  <= stop_det_n;
      busy_q      <= busy_n;
    end
  end

  // Next-state logic; bus START/STOP override whatever the byte engine is doing
  always_comb begin
    state_n     = state_q;
    bit_cnt_n   = bit_cnt_q;
    shift_in_n  = shift_in_q;
    shift_out_n = load_q ? rd_data : shift_out_q;
    rw_n        = rw_q;
    ack_on_n    = ack_on_q;
    prime_n     = prime_q;
    load_n      = rd_req_q;
    sda_oe_n    = sda_oe_q;
    wr_data_n   = wr_data_q;
    wr_valid_n  = 1'b0;
    rd_req_n    = 1'b0;
    start_det_n = 1'b0;
    stop_det_n  = 1'b0;
    busy_n      = busy_q;

    if (start_cond) begin
      state_n     = ADDR;
      bit_cnt_n   = 3'd0;
      sda_oe_n    = 1'b0;
      ack_on_n    = 1'b0;
      prime_n     = 1'b0;
      start_det_n = 1'b1;
    end else if (stop_cond) begin
      state_n    = IDLE;
      sda_oe_n   = 1'b0;
      busy_n     = 1'b0;
      stop_det_n = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          sda_oe_n = 1'b0;
          busy_n   = 1'b0;
        end
        ADDR: begin
          if (scl_rise) begin
            shift_in_n = {shift_in_q[6:0], sda_s};
            bit_cnt_n  = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              rw_n = sda_s;
              if (shift_in_q[6:0] == SLAVE_ADDR) begin
                busy_n   = 1'b1;
                ack_on_n = 1'b0;
                state_n  = ADDR_ACK;
              end else begin
                busy_n  = 1'b0;
                state_n = IDLE;
              end
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            if (!ack_on_q) begin
              sda_oe_n = 1'b1;
              ack_on_n = 1'b1;
            end else begin
              ack_on_n  = 1'b0;
              bit_cnt_n = 3'd0;
              prime_n   = 1'b0;
              if (rw_q) begin
                sda_oe_n = ~shift_out_q[7];
                state_n  = RD_BYTE;
              end else begin
                sda_oe_n = 1'b0;
                state_n  = WR_BYTE;
              end
            end
          end else if (scl_rise && ack_on_q && rw_q) begin
            rd_req_n = 1'b1;
          end
        end
        WR_BYTE: begin
          if (scl_rise) begin
            shift_in_n = {shift_in_q[6:0], sda_s};
            bit_cnt_n  = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              ack_on_n = 1'b0;
              state_n  = WR_ACK;
            end
          end
        end
        WR_ACK: begin
          if (scl_fall) begin
            if (!ack_on_q) begin
              sda_oe_n = 1'b1;
              ack_on_n = 1'b1;
            end else begin
              sda_oe_n  = 1'b0;
              ack_on_n  = 1'b0;
              bit_cnt_n = 3'd0;
              state_n   = WR_BYTE;
            end
          end else if (scl_rise && ack_on_q) begin
            wr_data_n  = shift_in_q;
            wr_valid_n = 1'b1;
          end
        end
        RD_BYTE: begin
          if (scl_fall) begin
            if (prime_q) begin
              sda_oe_n = ~shift_out_q[7];
              prime_n  = 1'b0;
            end else if (bit_cnt_q == 3'd7) begin
              sda_oe_n  = 1'b0;
              bit_cnt_n = bit_cnt_q + 3'd1;
              state_n   = RD_ACK;
            end else begin
              shift_out_n = {shift_out_q[6:0], 1'b0};
              sda_oe_n    = ~shift_out_q[6];
              bit_cnt_n   = bit_cnt_q + 3'd1;
            end
          end
        end
        RD_ACK: begin
          sda_oe_n = 1'b0;
          if (scl_rise) begin
            if (!sda_s) begin
              rd_req_n  = 1'b1;
              prime_n   = 1'b1;
              bit_cnt_n = 3'd0;
              state_n   = RD_BYTE;
            end else begin
              state_n = WAIT_STOP;
            end
          end
        end
        WAIT_STOP: begin
          sda_oe_n = 1'b0;
        end
        default: begin
          state_n  = IDLE;
          sda_oe_n = 1'b0;
          busy_n   = 1'b0;
        end
      endcase
    end
  end

  assign sda_oe    = sda_oe_q;
  assign wr_data   = wr_data_q;
  assign wr_valid  = wr_valid_q;
  assign rd_req    = rd_req_q;
  assign start_det = start_det_q;
  assign stop_det  = stop_det_q;
  assign busy      = busy_q;
  assign state     = state_q;

endmodule

// File: tb/tb_i2c_slave_ctrl.sv
// Self-checking bench for i2c_slave_ctrl: a bit-banged I2C master on a
// wired-AND SDA line, with scoreboards for written and read bytes.
module tb_i2c_slave_ctrl;

  localparam int Q = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_in;
  logic [7:0] rd_data = 8'h00;
  logic       sda_oe, wr_valid, rd_req, start_det, stop_det, busy;
  logic [7:0] wr_data;
  logic [3:0] state;

  int checks = 0;
  int failures = 0;
  int wr_cnt, rd_cnt, start_cnt, stop_cnt;
  bit oe_seen, busy_seen;

  logic [7:0] exp_wr[$];
  logic [7:0] rd_src[$];
  logic [7:0] exp_rd[$];

  assign sda_in = sda_m & ~sda_oe;

  i2c_slave_ctrl #(.SLAVE_ADDR(7'h50), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .scl_in(scl), .sda_in(sda_in), .sda_oe(sda_oe),
    .wr_data(wr_data), .wr_valid(wr_valid), .rd_req(rd_req), .rd_data(rd_data),
    .start_det(start_det), .stop_det(stop_det), .busy(busy), .state(state)
  );

  always #5 clk = ~clk;

  // Monitor: pops the write scoreboard on wr_valid, serves rd_data on rd_req, counts pulses
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (wr_valid) begin
        wr_cnt++;
        checks++;
        if (exp_wr.size() == 0) begin
          failures++;
          $display("[TB] FAIL wr_unexpected got=%h exp=none", wr_data);
        end else begin
          e = exp_wr.pop_front();
          if (wr_data !== e) begin
            failures++;
            $display("[TB] FAIL wr_data got=%h exp=%h", wr_data, e);
          end
        end
      end
      if (rd_req) begin
        rd_cnt++;
        if (rd_src.size() > 0) begin
          rd_data = rd_src.pop_front();
          exp_rd.push_back(rd_data);
        end
      end
      if (start_det) start_cnt++;
      if (stop_det) stop_cnt++;
      if (sda_oe) oe_seen = 1'b1;
      if (busy) busy_seen = 1'b1;
    end
  end

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic clear_counts();
    wr_cnt = 0; rd_cnt = 0; start_cnt = 0; stop_cnt = 0;
    oe_seen = 1'b0; busy_seen = 1'b0;
  endtask

  task automatic bus_start();
    sda_m = 1'b1; wait_q();
    scl = 1'b1; wait_q();
    sda_m = 1'b0; wait_q();
    scl = 1'b0; wait_q();
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; wait_q();
    scl = 1'b1; wait_q();
    sda_m = 1'b1; wait_q();
  endtask

  task automatic write_bit(input logic b);
    sda_m = b; wait_q();
    scl = 1'b1; wait_q(); wait_q();
    scl = 1'b0; wait_q();
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; wait_q();
    scl = 1'b1; wait_q();
    b = sda_in; wait_q();
    scl = 1'b0; wait_q();
  endtask

  task automatic write_byte(input logic [7:0] v, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) write_bit(v[i]);
    read_bit(b);
    ack = ~b;
  endtask

  task automatic read_byte(output logic [7:0] v, input logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      v[i] = b;
    end
    write_bit(~ack);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (sda_oe !== 1'b0) begin failures++; $display("[TB] FAIL reset_sda_oe got=%b exp=0", sda_oe); end
    checks++; if (state !== 4'd0) begin failures++; $display("[TB] FAIL reset_state got=%0d exp=0", state); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (wr_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_wr_valid got=%b exp=0", wr_valid); end
    checks++; if (wr_data !== 8'h00) begin failures++; $display("[TB] FAIL reset_wr_data got=%h exp=00", wr_data); end
    checks++; if ({rd_req, start_det, stop_det} !== 3'b000) begin failures++; $display("[TB] FAIL reset_pulses got=%b exp=000", {rd_req, start_det, stop_det}); end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_write();
    logic ack;
    clear_counts();
    bus_start();
    write_byte(8'hA0, ack);
    checks++; if (ack !== 1'b1) begin failures++; $display("[TB] FAIL write_addr_ack got=%b exp=1", ack); end
    checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL write_busy got=%b exp=1", busy); end
    exp_wr.push_back(8'h12);
    write_byte(8'h12, ack);
    checks++; if (ack !== 1'b1) begin failures++; $display("[TB] FAIL write_d0_ack got=%b exp=1", ack); end
    exp_wr.push_back(8'h34);
    write_byte(8'h34, ack);
    checks++; if (ack !== 1'b1) begin failures++; $display("[TB] FAIL write_d1_ack got=%b exp=1", ack); end
    bus_stop();
    checks++; if (wr_cnt !== 2) begin failures++; $display("[TB] FAIL write_wr_count got=%0d exp=2", wr_cnt); end
    checks++; if (stop_cnt !== 1) begin failures++; $display("[TB] FAIL write_stop_count got=%0d exp=1", stop_cnt); end
    checks++; if (start_cnt !== 1) begin failures++; $display("[TB] FAIL write_start_count got=%0d exp=1", start_cnt); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL write_busy_after got=%b exp=0", busy); end
    checks++; if (state !== 4'd0) begin failures++; $display("[TB] FAIL write_state_after got=%0d exp=0", state); end
  endtask

  task automatic test_mismatch();
    logic ack;
    clear_counts();
    bus_start();
    write_byte(8'hA2, ack);
    checks++; if (ack !== 1'b0) begin failures++; $display("[TB] FAIL mismatch_addr_ack got=%b exp=0", ack); end
    write_byte(8'h55, ack);
    checks++; if (ack !== 1'b0) begin failures++; $display("[TB] FAIL mismatch_data_ack got=%b exp=0", ack); end
    bus_stop();
    checks++; if (oe_seen !== 1'b0) begin failures++; $display("[TB] FAIL mismatch_oe_seen got=%b exp=0", oe_seen); end
    checks++; if (busy_seen !== 1'b0) begin failures++; $display("[TB] FAIL mismatch_busy_seen got=%b exp=0", busy_seen); end
    checks++; if (wr_cnt !== 0) begin failures++; $display("[TB] FAIL mismatch_wr_count got=%0d exp=0", wr_cnt); end
    checks++; if (start_cnt !== 1 || stop_cnt !== 1) begin failures++; $display("[TB] FAIL mismatch_start_stop got=%0d/%0d exp=1/1", start_cnt, stop_cnt); end
  endtask

  task automatic test_read();
    logic ack;
    logic [7:0] v, e;
    clear_counts();
    rd_src.push_back(8'hC3);
    rd_src.push_back(8'h5A);
    bus_start();
    write_byte(8'hA1, ack);
    checks++; if (ack !== 1'b1) begin failures++; $display("[TB] FAIL read_addr_ack got=%b exp=1", ack); end
    for (int k = 0; k < 2; k++) begin
      read_byte(v, (k == 0));
      checks++;
      if (exp_rd.size() == 0) begin
        failures++; $display("[TB] FAIL read_byte%0d got=%h exp=none", k, v);
      end else begin
        e = exp_rd.pop_front();
        if (v !== e) begin failures++; $display("[TB] FAIL read_byte%0d got=%h exp=%h", k, v, e); end
      end
    end
    checks++; if (state !== 4'd7) begin failures++; $display("[TB] FAIL read_wait_stop got=%0d exp=7", state); end
    bus_stop();
    checks++; if (state !== 4'd0) begin failures++; $display("[TB] FAIL read_idle got=%0d exp=0", state); end
    checks++; if (rd_cnt !== 2) begin failures++; $display("[TB] FAIL read_rd_req_count got=%0d exp=2", rd_cnt); end
  endtask

  task automatic test_repeated_start();
    logic ack;
    logic [7:0] v, e;
    clear_counts();
    bus_start();
    write_byte(8'hA0, ack);
    exp_wr.push_back(8'h07);
    write_byte(8'h07, ack);
    checks++; if (ack !== 1'b1) begin failures++; $display("[TB] FAIL rs_write_ack got=%b exp=1", ack); end
    rd_src.push_back(8'h96);
    bus_start();
    write_byte(8'hA1, ack);
    checks++; if (ack !== 1'b1) begin failures++; $display("[TB] FAIL rs_addr_ack got=%b exp=1", ack); end
    read_byte(v, 1'b0);
    checks++;
    if (exp_rd.size() == 0) begin
      failures++; $display("[TB] FAIL rs_read got=%h exp=none", v);
    end else begin
      e = exp_rd.pop_front();
      if (v !== e) begin failures++; $display("[TB] FAIL rs_read got=%h exp=%h", v, e); end
    end
    bus_stop();
    checks++; if (start_cnt !== 2) begin failures++; $display("[TB] FAIL rs_start_count got=%0d exp=2", start_cnt); end
    checks++; if (wr_cnt !== 1) begin failures++; $display("[TB] FAIL rs_wr_count got=%0d exp=1", wr_cnt); end
  endtask

  task automatic test_stop_mid_byte();
    logic ack;
    logic [7:0] v;
    clear_counts();
    v = 8'hC3;
    bus_start();
    write_byte(8'hA0, ack);
    for (int i = 7; i >= 4; i--) write_bit(v[i]);
    bus_stop();
    repeat (4) @(negedge clk);
    checks++; if (state !== 4'd0) begin failures++; $display("[TB] FAIL stopmid_state got=%0d exp=0", state); end
    checks++; if (wr_cnt !== 0) begin failures++; $display("[TB] FAIL stopmid_wr_count got=%0d exp=0", wr_cnt); end
    checks++; if (sda_oe !== 1'b0) begin failures++; $display("[TB] FAIL stopmid_sda_oe got=%b exp=0", sda_oe); end
    checks++; if (stop_cnt !== 1) begin failures++; $display("[TB] FAIL stopmid_stop_count got=%0d exp=1", stop_cnt); end
  endtask

  task automatic test_reset_during_ack();
    logic ack;
    logic [7:0] a;
    int n;
    clear_counts();
    a = 8'hA0;
    bus_start();
    for (int i = 7; i >= 0; i--) write_bit(a[i]);
    n = 0;
    while (!sda_oe && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++; if (sda_oe !== 1'b1) begin failures++; $display("[TB] FAIL rstack_driving got=%b exp=1", sda_oe); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if (sda_oe !== 1'b0) begin failures++; $display("[TB] FAIL rstack_sda_oe got=%b exp=0", sda_oe); end
    checks++; if (state !== 4'd0) begin failures++; $display("[TB] FAIL rstack_state got=%0d exp=0", state); end
    bus_stop();
    clear_counts();
    bus_start();
    write_byte(8'hA0, ack);
    checks++; if (ack !== 1'b1) begin failures++; $display("[TB] FAIL rstack_again_ack got=%b exp=1", ack); end
    exp_wr.push_back(8'hFF);
    write_byte(8'hFF, ack);
    exp_wr.push_back(8'h00);
    write_byte(8'h00, ack);
    checks++; if (ack !== 1'b1) begin failures++; $display("[TB] FAIL rstack_data_ack got=%b exp=1", ack); end
    bus_stop();
    checks++; if (wr_cnt !== 2) begin failures++; $display("[TB] FAIL rstack_wr_count got=%0d exp=2", wr_cnt); end
    checks++; if (exp_wr.size() !== 0) begin failures++; $display("[TB] FAIL scoreboard_left got=%0d exp=0", exp_wr.size()); end
  endtask

  initial begin
    clear_counts();
    test_reset();
    test_write();
    test_mismatch();
    test_read();
    test_repeated_start();
    test_stop_mid_byte();
    test_reset_during_ack();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
